// File: rtl/bsg_chip_io_link_reset_seq_pkg.sv
// Shared types for the IO link reset sequencer: state encoding, tag-payload mirrors
// and the state-to-output decode used by the top-level FSM.
package bsg_chip_io_link_reset_seq_pkg;

   typedef enum logic [3:0] {
      e_idle,
      e_assert_all,
      e_token_set,
      e_token_clr,
      e_up_io_rel,
      e_down_io_rel,
      e_core_rel,
      e_ct_rel,
      e_done
   } bsg_link_reset_seq_state_e;

   // Field order matches the io-side and core-side link tag payloads.
   typedef struct packed {
      logic up_link_reset;
      logic down_link_reset;
      logic async_token_reset;
   } bsg_link_io_payload_s;

   typedef struct packed {
      logic up_link_reset;
      logic down_link_reset;
      logic ct_reset;
      logic fifo_reset;
   } bsg_link_core_payload_s;

   typedef struct packed {
      bsg_link_io_payload_s   io;
      bsg_link_core_payload_s core;
      logic                   busy;
      logic                   done;
   } bsg_link_reset_seq_out_s;

   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   // Releases are cumulative, so each reset is simply "not yet past its release state".
   function automatic bsg_link_reset_seq_out_s decode_outputs(input bsg_link_reset_seq_state_e s);
      bsg_link_reset_seq_out_s o;
      o.io.up_link_reset       = (s < e_up_io_rel);
      o.io.down_link_reset     = (s < e_down_io_rel);
      o.io.async_token_reset   = (s == e_token_set);
      o.core.up_link_reset     = (s < e_core_rel);
      o.core.down_link_reset   = (s < e_core_rel);
      o.core.ct_reset          = (s < e_ct_rel);
      o.core.fifo_reset        = (s < e_done);
      o.busy                   = (s != e_idle) && (s != e_done);
      o.done                   = (s == e_done);
      return o;
   endfunction

endpackage

// File: rtl/bsg_chip_io_link_reset_seq_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags the last cycle of a step.
module bsg_chip_io_link_reset_seq_timer #(
   parameter int unsigned width_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic               zero_o
);

   logic [width_p-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - width_p'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_chip_io_link_reset_seq.sv
// Timed bring-up / retrain sequencer for one IO link and channel tunnel; Moore outputs
// are registered from the next-state decode so they carry no input-to-output path.
module bsg_chip_io_link_reset_seq
   import bsg_chip_io_link_reset_seq_pkg::*;
#(
   parameter int unsigned step_cycles_p        = 16,
   parameter int unsigned token_pulse_cycles_p = 4,
   parameter bit          auto_start_p         = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic start_i,
   output logic io_up_link_reset_o,
   output logic io_down_link_reset_o,
   output logic async_token_reset_o,
   output logic core_up_link_reset_o,
   output logic core_down_link_reset_o,
   output logic ct_reset_o,
   output logic fifo_reset_o,
   output logic busy_o,
   output logic done_o
);

   localparam int unsigned max_cycles_lp = (step_cycles_p > token_pulse_cycles_p)
                                           ? step_cycles_p : token_pulse_cycles_p;
   localparam int unsigned ctr_width_lp  = safe_clog2(max_cycles_lp);

   bsg_link_reset_seq_state_e state_q, state_d;
   bsg_link_reset_seq_out_s   out_q;
   logic                      ctr_zero;
   logic                      ctr_load;
   logic [ctr_width_lp-1:0]   ctr_load_val;

   always_comb begin
      state_d = state_q;
      case (state_q)
         e_idle: if (start_i || auto_start_p) state_d = e_assert_all;
         e_done: if (start_i) state_d = e_assert_all;
         default: begin
            // Retrain beats step expiry.
            if (start_i) begin
               state_d = e_assert_all;
            end else if (ctr_zero) begin
               state_d = bsg_link_reset_seq_state_e'(state_q + 4'd1);
            end
         end
      endcase
   end

   // Reload on every state entry, and on start_i so a held start keeps ASSERT_ALL fresh.
   assign ctr_load     = start_i || (state_d != state_q);
   assign ctr_load_val = (state_d == e_token_set) ? ctr_width_lp'(token_pulse_cycles_p - 1)
                                                  : ctr_width_lp'(step_cycles_p - 1);

   bsg_chip_io_link_reset_seq_timer #(
      .width_p(ctr_width_lp)
   ) timer (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (ctr_load),
      .load_val_i(ctr_load_val),
      .zero_o    (ctr_zero)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_idle;
         out_q   <= decode_outputs(e_idle);
      end else begin
         state_q <= state_d;
         out_q   <= decode_outputs(state_d);
      end
   end

   assign io_up_link_reset_o     = out_q.io.up_link_reset;
   assign io_down_link_reset_o   = out_q.io.down_link_reset;
   assign async_token_reset_o    = out_q.io.async_token_reset;
   assign core_up_link_reset_o   = out_q.core.up_link_reset;
   assign core_down_link_reset_o = out_q.core.down_link_reset;
   assign ct_reset_o             = out_q.core.ct_reset;
   assign fifo_reset_o           = out_q.core.fifo_reset;
   assign busy_o                 = out_q.busy;
   assign done_o                 = out_q.done;

endmodule

// File: tb/tb_bsg_chip_io_link_reset_seq.sv
// Directed vector bench: three sequencer configurations driven from per-cycle tables.
module tb_bsg_chip_io_link_reset_seq;

   // Observed vector: {io_up, io_down, token, core_up, core_down, ct, fifo, busy, done}
   localparam logic [8:0] S_IDLE   = 9'b110_1111_00;
   localparam logic [8:0] S_ASSERT = 9'b110_1111_10;
   localparam logic [8:0] S_TSET   = 9'b111_1111_10;
   localparam logic [8:0] S_TCLR   = 9'b110_1111_10;
   localparam logic [8:0] S_UPIO   = 9'b010_1111_10;
   localparam logic [8:0] S_DNIO   = 9'b000_1111_10;
   localparam logic [8:0] S_CORE   = 9'b000_0011_10;
   localparam logic [8:0] S_CT     = 9'b000_0001_10;
   localparam logic [8:0] S_DONE   = 9'b000_0000_01;

   typedef struct {
      int         cyc;
      logic       rst;
      logic       start;
      logic [8:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic [2:0] rst_v = 3'b111;
   logic [2:0] start_v = 3'b000;
   logic [8:0] obs_a, obs_b, obs_c;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       tbl[$];

   always #5 clk = ~clk;

   bsg_chip_io_link_reset_seq #(
      .step_cycles_p(4), .token_pulse_cycles_p(2), .auto_start_p(1'b0)
   ) dut_a (
      .clk_i(clk), .reset_i(rst_v[0]), .start_i(start_v[0]),
      .io_up_link_reset_o(obs_a[8]), .io_down_link_reset_o(obs_a[7]),
      .async_token_reset_o(obs_a[6]), .core_up_link_reset_o(obs_a[5]),
      .core_down_link_reset_o(obs_a[4]), .ct_reset_o(obs_a[3]),
      .fifo_reset_o(obs_a[2]), .busy_o(obs_a[1]), .done_o(obs_a[0])
   );

   bsg_chip_io_link_reset_seq #(
      .step_cycles_p(4), .token_pulse_cycles_p(2), .auto_start_p(1'b1)
   ) dut_b (
      .clk_i(clk), .reset_i(rst_v[1]), .start_i(start_v[1]),
      .io_up_link_reset_o(obs_b[8]), .io_down_link_reset_o(obs_b[7]),
      .async_token_reset_o(obs_b[6]), .core_up_link_reset_o(obs_b[5]),
      .core_down_link_reset_o(obs_b[4]), .ct_reset_o(obs_b[3]),
      .fifo_reset_o(obs_b[2]), .busy_o(obs_b[1]), .done_o(obs_b[0])
   );

   bsg_chip_io_link_reset_seq #(
      .step_cycles_p(1), .token_pulse_cycles_p(1), .auto_start_p(1'b0)
   ) dut_c (
      .clk_i(clk), .reset_i(rst_v[2]), .start_i(start_v[2]),
      .io_up_link_reset_o(obs_c[8]), .io_down_link_reset_o(obs_c[7]),
      .async_token_reset_o(obs_c[6]), .core_up_link_reset_o(obs_c[5]),
      .core_down_link_reset_o(obs_c[4]), .ct_reset_o(obs_c[3]),
      .fifo_reset_o(obs_c[2]), .busy_o(obs_c[1]), .done_o(obs_c[0])
   );

   function automatic logic [8:0] get_obs(input int k);
      case (k)
         0:       return obs_a;
         1:       return obs_b;
         default: return obs_c;
      endcase
   endfunction

   function automatic void add(input int c, input logic r, input logic s, input logic [8:0] e);
      vec_t v;
      v.cyc = c; v.rst = r; v.start = s; v.exp = e;
      tbl.push_back(v);
   endfunction

   // Cycle 0 is the cycle after the next edge. An entry drives rst/start during its cycle
   // and checks outputs in that same cycle; inputs fall back to 0 between entries.
   task automatic run_table(input int k, input string name);
      int         cyc;
      logic [8:0] got;
      @(posedge clk); #1;
      cyc = 0;
      foreach (tbl[i]) begin
         while (cyc < tbl[i].cyc) begin
            @(posedge clk); #1;
            cyc++;
            rst_v[k]   = 1'b0;
            start_v[k] = 1'b0;
         end
         rst_v[k]   = tbl[i].rst;
         start_v[k] = tbl[i].start;
         got = get_obs(k);
         n_vec++;
         if (got !== tbl[i].exp) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %b want %b", name, cyc, got, tbl[i].exp);
         end
      end
      tbl.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      rst_v[2] = 1'b0;

      // dut_a: idle, full sequence, retrain, held start, start-vs-expiry, mid-run reset
      add(0, 0, 0, S_IDLE);   add(5, 0, 0, S_IDLE);   add(9, 0, 0, S_IDLE);
      add(10, 0, 1, S_IDLE);
      add(11, 0, 0, S_ASSERT); add(14, 0, 0, S_ASSERT);
      add(15, 0, 0, S_TSET);   add(16, 0, 0, S_TSET);
      add(17, 0, 0, S_TCLR);   add(20, 0, 0, S_TCLR);
      add(21, 0, 0, S_UPIO);   add(24, 0, 0, S_UPIO);
      add(25, 0, 0, S_DNIO);   add(28, 0, 0, S_DNIO);
      add(29, 0, 0, S_CORE);   add(32, 0, 0, S_CORE);
      add(33, 0, 0, S_CT);     add(36, 0, 0, S_CT);
      add(37, 0, 0, S_DONE);   add(45, 0, 0, S_DONE);
      add(46, 0, 1, S_DONE);
      add(47, 0, 0, S_ASSERT); add(51, 0, 0, S_TSET);
      add(60, 0, 1, S_UPIO);
      add(61, 0, 0, S_ASSERT); add(64, 0, 0, S_ASSERT);
      add(65, 0, 0, S_TSET);   add(75, 0, 0, S_DNIO);
      add(86, 0, 0, S_CT);     add(87, 0, 0, S_DONE);
      add(88, 0, 1, S_DONE);   add(89, 0, 1, S_ASSERT);
      add(90, 0, 1, S_ASSERT); add(91, 0, 1, S_ASSERT);
      add(92, 0, 1, S_ASSERT); add(93, 0, 0, S_ASSERT);
      add(96, 0, 1, S_ASSERT); add(97, 0, 0, S_ASSERT);
      add(100, 0, 0, S_ASSERT); add(101, 0, 0, S_TSET);
      add(102, 1, 0, S_TSET);  add(103, 0, 0, S_IDLE);
      add(110, 0, 0, S_IDLE);  add(111, 0, 1, S_IDLE);
      add(112, 0, 0, S_ASSERT); add(115, 0, 0, S_ASSERT);
      add(116, 0, 0, S_TSET);
      run_table(0, "cfg_a");

      // dut_c: one-cycle steps, retrain from DONE and from a zero-count step
      add(0, 0, 0, S_IDLE);   add(1, 0, 1, S_IDLE);
      add(2, 0, 0, S_ASSERT); add(3, 0, 0, S_TSET);
      add(4, 0, 0, S_TCLR);   add(5, 0, 0, S_UPIO);
      add(6, 0, 0, S_DNIO);   add(7, 0, 0, S_CORE);
      add(8, 0, 0, S_CT);     add(9, 0, 0, S_DONE);
      add(12, 0, 0, S_DONE);  add(13, 0, 1, S_DONE);
      add(14, 0, 0, S_ASSERT); add(15, 0, 1, S_TSET);
      add(16, 0, 0, S_ASSERT); add(17, 0, 0, S_TSET);
      run_table(2, "cfg_c");

      // dut_b: auto start after reset release, no start_i
      add(0, 1, 0, S_IDLE);   add(1, 0, 0, S_IDLE);
      add(2, 0, 0, S_ASSERT); add(5, 0, 0, S_ASSERT);
      add(6, 0, 0, S_TSET);   add(8, 0, 0, S_TCLR);
      add(27, 0, 0, S_CT);    add(28, 0, 0, S_DONE);
      add(35, 0, 0, S_DONE);
      run_table(1, "cfg_b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
